// File: rtl/reg_bank_pkg.sv
// Shared definitions for the control/status register bank and its upstream api block.
package reg_bank_pkg;

    localparam logic [3:0] REG_EV_ACK   = 4'd0;
    localparam logic [3:0] REG_EV       = 4'd1;
    localparam logic [3:0] REG_IRQ_MASK = 4'd2;
    localparam logic [3:0] REG_CFG_BASE = 4'd4;

    typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} irq_state_t;

endpackage

// File: rtl/reg_bank_if.sv
// Register-write stream from api into reg_bank, plus the event/irq return path.
interface reg_bank_if;

    logic [31:0] wr_reg;
    logic [3:0]  wr_reg_addr;
    logic        wr_reg_changed;
    logic [31:0] ev_reg;
    logic        irq_req;

    modport master (
        output wr_reg, wr_reg_addr, wr_reg_changed,
        input  ev_reg, irq_req
    );

    modport slave (
        input  wr_reg, wr_reg_addr, wr_reg_changed,
        output ev_reg, irq_req
    );

endinterface

// File: rtl/toggle_detect.sv
// Turns a level-toggle handshake into a one-cycle strobe per toggle.
module toggle_detect (
    input  logic clk,
    input  logic reset,
    input  logic tog,
    output logic stb
);

    logic tog_q;

    // Tracking the live level through reset means a toggle left high across reset is not a write.
    always_ff @(posedge clk) begin
        tog_q <= tog;
    end

    assign stb = (tog ^ tog_q) & ~reset;

endmodule

// File: rtl/reg_bank.sv
// Control/status register bank: IRQ mask, config registers, sticky events and IRQ hold-off.
module reg_bank #(
    parameter int unsigned NUM_CFG = 8,
    parameter int unsigned HOLDOFF = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_bank_if.slave              bus,
    input  logic [31:0]            events,
    output logic [31:0]            irq_mask,
    output logic [NUM_CFG*32-1:0]  cfg,
    output logic [NUM_CFG-1:0]     cfg_stb
);

    import reg_bank_pkg::*;

    localparam int unsigned    CntW    = $clog2(HOLDOFF + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(HOLDOFF - 1);

    logic                      wr_stb;
    logic                      ack_wr;
    logic                      mask_wr;
    logic                      masked;
    logic [31:0]               clr;
    logic [NUM_CFG-1:0]        cfg_hit;
    logic [31:0]               pending_q;
    logic [31:0]               irq_mask_q;
    logic [NUM_CFG-1:0][31:0]  cfg_q;
    logic [NUM_CFG-1:0]        cfg_stb_q;
    irq_state_t                state_q;
    logic [CntW-1:0]           cnt_q;
    logic                      irq_q;

    toggle_detect u_toggle_detect (
        .clk   (clk),
        .reset (reset),
        .tog   (bus.wr_reg_changed),
        .stb   (wr_stb)
    );

    assign ack_wr  = wr_stb && (bus.wr_reg_addr == REG_EV_ACK);
    assign mask_wr = wr_stb && (bus.wr_reg_addr == REG_IRQ_MASK);
    assign clr     = ack_wr ? bus.wr_reg : 32'h0;
    assign masked  = |(pending_q & irq_mask_q);

    always_comb begin
        cfg_hit = '0;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (wr_stb && (bus.wr_reg_addr == REG_CFG_BASE + 4'(k))) begin
                cfg_hit[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            irq_mask_q <= '0;
            cfg_q      <= '0;
            cfg_stb_q  <= '0;
            state_q    <= reg_bank_pkg::IDLE;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            // Set wins over clear on the same bit.
            pending_q <= (pending_q & ~clr) | events;
            if (mask_wr) begin
                irq_mask_q <= bus.wr_reg;
            end
            for (int k = 0; k < NUM_CFG; k++) begin
                if (cfg_hit[k]) begin
                    cfg_q[k] <= bus.wr_reg;
                end
            end
            cfg_stb_q <= cfg_hit;

            unique case (state_q)
                reg_bank_pkg::IDLE: begin
                    if (masked) begin
                        state_q <= reg_bank_pkg::ASSERT;
                        irq_q   <= 1'b1;
                    end
                end
                reg_bank_pkg::ASSERT: begin
                    if (ack_wr) begin
                        state_q <= reg_bank_pkg::HOLDOFF;
                        cnt_q   <= CntLoad;
                        irq_q   <= 1'b0;
                    end else if (!masked) begin
                        state_q <= reg_bank_pkg::IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                reg_bank_pkg::HOLDOFF: begin
                    if (ack_wr) begin
                        cnt_q <= CntLoad;
                    end else if (cnt_q == '0) begin
                        state_q <= reg_bank_pkg::IDLE;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= reg_bank_pkg::IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ev_reg  = pending_q;
    assign bus.irq_req = irq_q;
    assign irq_mask    = irq_mask_q;
    assign cfg         = cfg_q;
    assign cfg_stb     = cfg_stb_q;

endmodule

// File: tb/tb_reg_bank.sv
// Cycle-level scoreboard bench for reg_bank plus directed checks of the key scenarios.
module tb_reg_bank;

    localparam int unsigned NUM_CFG = 8;
    localparam int unsigned HOLDOFF = 64;

    typedef struct {
        logic [31:0]           ev;
        logic [31:0]           mask;
        logic [NUM_CFG*32-1:0] cfg;
        logic [NUM_CFG-1:0]    stb;
        logic                  irq;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [31:0]           events;
    logic [31:0]           irq_mask;
    logic [NUM_CFG*32-1:0] cfg;
    logic [NUM_CFG-1:0]    cfg_stb;

    reg_bank_if bus ();

    reg_bank #(
        .NUM_CFG (NUM_CFG),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .events   (events),
        .irq_mask (irq_mask),
        .cfg      (cfg),
        .cfg_stb  (cfg_stb)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    exp_t sb[$];

    // Reference model state
    logic [31:0]           m_pend = '0;
    logic [31:0]           m_mask = '0;
    logic [NUM_CFG*32-1:0] m_cfg  = '0;
    logic [NUM_CFG-1:0]    m_stb  = '0;
    logic                  m_tog  = 1'b0;
    int                    m_st   = 0;  // 0 idle, 1 asserted, 2 hold-off
    int                    m_cnt  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model with the inputs currently driven, clock the DUT, compare.
    task automatic step();
        exp_t e;
        exp_t g;
        logic stb;
        logic ack;
        logic hit;
        int   a;
        stb = bus.wr_reg_changed ^ m_tog;
        a   = int'(bus.wr_reg_addr);
        if (reset) begin
            m_pend = '0; m_mask = '0; m_cfg = '0; m_stb = '0; m_st = 0; m_cnt = 0;
        end else begin
            ack = stb && (a == 0);
            hit = |(m_pend & m_mask);
            case (m_st)
                0: if (hit) m_st = 1;
                1: begin
                    if (ack) begin
                        m_st = 2; m_cnt = HOLDOFF - 1;
                    end else if (!hit) begin
                        m_st = 0;
                    end
                end
                default: begin
                    if (ack) m_cnt = HOLDOFF - 1;
                    else if (m_cnt == 0) m_st = 0;
                    else m_cnt--;
                end
            endcase
            m_pend = (m_pend & ~(ack ? bus.wr_reg : 32'h0)) | events;
            m_stb  = '0;
            if (stb && a == 2) m_mask = bus.wr_reg;
            if (stb && a >= 4 && a < 4 + NUM_CFG) begin
                m_cfg[(a - 4) * 32 +: 32] = bus.wr_reg;
                m_stb[a - 4] = 1'b1;
            end
        end
        m_tog  = bus.wr_reg_changed;
        e.ev   = m_pend;
        e.mask = m_mask;
        e.cfg  = m_cfg;
        e.stb  = m_stb;
        e.irq  = (m_st == 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            g = sb.pop_front();
            check("ev_reg", 256'(bus.ev_reg), 256'(g.ev));
            check("irq_mask", 256'(irq_mask), 256'(g.mask));
            check("cfg", 256'(cfg), 256'(g.cfg));
            check("cfg_stb", 256'(cfg_stb), 256'(g.stb));
            check("irq_req", 256'(bus.irq_req), 256'(g.irq));
        end
        events = '0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        bus.wr_reg         = data;
        bus.wr_reg_addr    = addr;
        bus.wr_reg_changed = ~bus.wr_reg_changed;
        step();
    endtask

    initial begin
        reset              = 1'b1;
        events             = '0;
        bus.wr_reg         = '0;
        bus.wr_reg_addr    = '0;
        bus.wr_reg_changed = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Config write
        wr(4'd5, 32'h1234_5678);
        check("cfg1_value", 256'(cfg[63:32]), 256'h1234_5678);
        check("cfg1_stb", 256'(cfg_stb), 256'h2);
        check("cfg0_untouched", 256'(cfg[31:0]), 256'h0);
        step();
        check("cfg_stb_one_cycle", 256'(cfg_stb), 256'h0);

        // Event -> IRQ
        wr(4'd2, 32'h1);
        events = 32'h1;
        step();
        check("ev_after_1", 256'(bus.ev_reg), 256'h1);
        check("irq_not_yet", 256'(bus.irq_req), 256'h0);
        step();
        check("irq_after_2", 256'(bus.irq_req), 256'h1);

        // Ack, then event during hold-off
        wr(4'd0, 32'h1);
        check("ack_clears_ev", 256'(bus.ev_reg), 256'h0);
        check("ack_drops_irq", 256'(bus.irq_req), 256'h0);
        events = 32'h1;
        step();
        for (int i = 0; i < HOLDOFF - 2; i++) step();
        check("holdoff_last_low", 256'(bus.irq_req), 256'h0);
        step();
        check("idle_gap_low", 256'(bus.irq_req), 256'h0);
        step();
        check("irq_rerises", 256'(bus.irq_req), 256'h1);

        // Set wins over clear
        events = 32'h8;
        step();
        events = 32'h8;
        wr(4'd0, 32'h8);
        check("set_wins", 256'(bus.ev_reg[3]), 256'h1);

        // Back-to-back writes, then ignored addresses
        wr(4'd4, 32'hA);
        wr(4'd2, 32'hF);
        check("b2b_cfg0", 256'(cfg[31:0]), 256'hA);
        check("b2b_mask", 256'(irq_mask), 256'hF);
        wr(4'd3, 32'hFFFF_FFFF);
        wr(4'd15, 32'hFFFF_FFFF);
        wr(4'd1, 32'hFFFF_FFFF);
        check("ignored_cfg", 256'(cfg), {192'h0, 32'h1234_5678, 32'hA});
        check("ignored_mask", 256'(irq_mask), 256'hF);
        check("ignored_stb", 256'(cfg_stb), 256'h0);

        // Reset during hold-off with a pending toggle-high write
        wr(4'd0, 32'h0);
        for (int i = 0; i < 5; i++) step();
        bus.wr_reg         = 32'hDEAD_BEEF;
        bus.wr_reg_addr    = 4'd4;
        bus.wr_reg_changed = 1'b1;
        reset              = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        check("rst_ev", 256'(bus.ev_reg), 256'h0);
        check("rst_irq", 256'(bus.irq_req), 256'h0);
        check("rst_cfg", 256'(cfg), 256'h0);
        check("rst_stb", 256'(cfg_stb), 256'h0);
        check("rst_mask", 256'(irq_mask), 256'h0);

        // Still functional after reset
        wr(4'd6, 32'h55);
        check("post_rst_cfg2", 256'(cfg[95:64]), 256'h55);
        check("post_rst_stb", 256'(cfg_stb), 256'h4);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
